// File: rtl/rr_arbiter_fsm.sv
// Registered round-robin arbiter: rotating priority, multi-cycle hold, optional hold-time limit.
// Latency: request sampled at one edge is granted after that edge; every release is followed by one idle cycle.
module rr_arbiter_fsm #(
    parameter int N        = 8,
    parameter int IDX_W    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             forced_rel
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0]     MAX_HOLD_C = 8'(MAX_HOLD);
    localparam logic [IDX_W:0] N_C        = (IDX_W+1)'(N);
    localparam logic [IDX_W-1:0] LAST_C   = IDX_W'(N - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [7:0]       hold_q, hold_d;
    logic             vld_q, vld_d;
    logic             frel_q, frel_d;

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] sel;
    logic             rel_done, rel_wd, rel_max, release_now;

    // Scan offsets high to low so the smallest offset from ptr wins.
    always_comb begin
        sel = '0;
        pos = '0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (pos >= N_C) begin
                pos = pos - N_C;
            end
            if (req[pos]) begin
                sel = pos[IDX_W-1:0];
            end
        end
    end

    assign rel_done    = done;
    assign rel_wd      = !req[idx_q];
    assign rel_max     = (MAX_HOLD != 0) && (hold_q == MAX_HOLD_C);
    assign release_now = (state_q == BUSY) && (rel_done || rel_wd || rel_max);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            hold_q  <= '0;
            vld_q   <= 1'b0;
            frel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            vld_q   <= vld_d;
            frel_q  <= frel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = BUSY;
            BUSY:    if (release_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        vld_d   = vld_q;
        frel_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    idx_d        = sel;
                    vld_d        = 1'b1;
                    hold_d       = 8'd1;
                end
            end
            BUSY: begin
                if (release_now) begin
                    grant_d = '0;
                    idx_d   = '0;
                    vld_d   = 1'b0;
                    ptr_d   = (idx_q == LAST_C) ? '0 : idx_q + 1'b1;
                    // A limit expiry only counts as forced when nothing else released the grant.
                    frel_d  = rel_max && !rel_done && !rel_wd;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = vld_q;
    assign forced_rel  = frel_q;

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Bench for rr_arbiter_fsm: an N=8/MAX_HOLD=4 instance and an N=5/no-limit instance
// driven by directed steps then random traffic, compared against a behavioural model.
module tb_rr_arbiter_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req8;
    logic       done8;
    logic [4:0] req5;
    logic       done5;

    logic [7:0] g8;
    logic [2:0] gi8;
    logic       gv8, fr8;
    logic [4:0] g5;
    logic [2:0] gi5;
    logic       gv5, fr5;

    int vectors     = 0;
    int miscompares = 0;

    // Model state, index 0 = N8 instance, 1 = N5 instance.
    int m_owner [2];
    int m_ptr   [2];
    int m_hold  [2];
    bit m_fr    [2];
    int m_n     [2] = '{8, 5};
    int m_max   [2] = '{4, 0};

    always #5 clk = ~clk;

    rr_arbiter_fsm #(.N(8), .IDX_W(3), .MAX_HOLD(4)) u8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .done(done8),
        .grant(g8), .grant_idx(gi8), .grant_valid(gv8), .forced_rel(fr8)
    );

    rr_arbiter_fsm #(.N(5), .IDX_W(3), .MAX_HOLD(0)) u5 (
        .clk(clk), .rst_n(rst_n), .req(req5), .done(done5),
        .grant(g5), .grant_idx(gi5), .grant_valid(gv5), .forced_rel(fr5)
    );

    task automatic model_edge(input int d, input logic rst, input logic [7:0] r, input logic dn);
        bit by_done, by_drop, by_limit;
        if (!rst) begin
            m_owner[d] = -1;
            m_ptr[d]   = 0;
            m_hold[d]  = 0;
            m_fr[d]    = 0;
        end else if (m_owner[d] < 0) begin
            m_fr[d] = 0;
            for (int k = 0; k < m_n[d]; k++) begin
                int c;
                c = (m_ptr[d] + k) % m_n[d];
                if (r[c]) begin
                    m_owner[d] = c;
                    m_hold[d]  = 1;
                    break;
                end
            end
        end else begin
            by_done  = (dn === 1'b1);
            by_drop  = (r[m_owner[d]] === 1'b0);
            by_limit = (m_max[d] != 0) && (m_hold[d] == m_max[d]);
            if (by_done || by_drop || by_limit) begin
                m_fr[d]    = by_limit && !by_done && !by_drop;
                m_ptr[d]   = (m_owner[d] + 1) % m_n[d];
                m_owner[d] = -1;
            end else begin
                m_fr[d]   = 0;
                m_hold[d] = (m_hold[d] >= 255) ? 255 : m_hold[d] + 1;
            end
        end
    endtask

    task automatic chk(input int d, input logic [7:0] g, input logic [2:0] gi,
                       input logic gv, input logic fr);
        logic [7:0] eg;
        logic [2:0] ei;
        logic       ev;
        logic       ef;
        eg = (m_owner[d] >= 0) ? (8'd1 << m_owner[d]) : 8'd0;
        ei = (m_owner[d] >= 0) ? 3'(m_owner[d]) : 3'd0;
        ev = (m_owner[d] >= 0);
        ef = m_fr[d];
        vectors++;
        assert (g === eg) else begin
            miscompares++;
            $error("FAIL inst%0d grant t=%0t got %b want %b", d, $time, g, eg);
        end
        vectors++;
        assert (gi === ei) else begin
            miscompares++;
            $error("FAIL inst%0d grant_idx t=%0t got %0d want %0d", d, $time, gi, ei);
        end
        vectors++;
        assert (gv === ev) else begin
            miscompares++;
            $error("FAIL inst%0d grant_valid t=%0t got %b want %b", d, $time, gv, ev);
        end
        vectors++;
        assert (fr === ef) else begin
            miscompares++;
            $error("FAIL inst%0d forced_rel t=%0t got %b want %b", d, $time, fr, ef);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge(0, rst_n, req8, done8);
        model_edge(1, rst_n, {3'b000, req5}, done5);
        #1;
        chk(0, g8, gi8, gv8, fr8);
        chk(1, {3'b000, g5}, gi5, gv5, fr5);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1; m_ptr[d] = 0; m_hold[d] = 0; m_fr[d] = 0;
        end
        rst_n = 1'b0; req8 = 8'h00; done8 = 1'b0; req5 = 5'h00; done5 = 1'b0;
        #1;

        // Reset, single request, done pulse, then a full request starts at ptr=3.
        run(2);
        rst_n = 1'b1; req8 = 8'b0000_0100;
        run(3);
        done8 = 1'b1; cyc(); done8 = 1'b0;
        req8 = 8'hFF;
        run(3);

        // Full contention rotation from a fresh reset, done every third cycle.
        rst_n = 1'b0; req8 = 8'h00; run(1); rst_n = 1'b1;
        req8 = 8'hFF;
        for (int i = 0; i < 30; i++) begin
            done8 = (i % 3 == 2);
            cyc();
        end
        done8 = 1'b0; req8 = 8'h00; run(2);

        // N=5 wrap: park ptr at 4, then 00011 grants 0 and next 1.
        req5 = 5'b01000; run(2);
        done5 = 1'b1; cyc(); done5 = 1'b0;
        req5 = 5'b00011; run(2);
        done5 = 1'b1; cyc(); done5 = 1'b0;
        run(2);
        done5 = 1'b1; cyc(); done5 = 1'b0;
        req5 = 5'b00000; run(2);

        // Hold limit on requester 5, alone and then with a competitor.
        req8 = 8'b0010_0000; run(14);
        req8 = 8'b0010_0001; run(12);
        // Owner withdraws mid-grant.
        req8 = 8'b0010_0000; run(3);
        req8 = 8'b0000_0000; run(2);
        // done coincides with the limit cycle.
        req8 = 8'b1000_0000; run(4);
        done8 = 1'b1; cyc(); done8 = 1'b0;
        run(2);
        req8 = 8'h00; run(2);

        // Reset while requester 6 owns the grant.
        req8 = 8'b0100_0000; run(2);
        rst_n = 1'b0; cyc(); rst_n = 1'b1;
        req8 = 8'hFF; run(3);
        req8 = 8'h00; run(2);

        // Unlimited hold past the counter saturation point.
        req5 = 5'b00001; run(300);
        done5 = 1'b1; cyc(); done5 = 1'b0;
        req5 = 5'b00000; run(2);

        // Random traffic with slowly changing requests and sparse resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req8 = 8'($urandom);
            if ($urandom_range(0, 3) == 0) req5 = 5'($urandom);
            done8 = ($urandom_range(0, 5) == 0);
            done5 = ($urandom_range(0, 5) == 0);
            rst_n = ($urandom_range(0, 299) != 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_fsm.md
Name: rr_arbiter_fsm

Overview:
- Registered round-robin arbiter that shares one resource between N requesters.
- It does the sequential job that combinational priority encoders cannot: it rotates the priority so every requester gets a turn.
- It also holds the grant for multi-cycle transactions and enforces a maximum hold time.
- Outputs are a one-hot grant and a binary-encoded grant index, which the downstream datapath mux uses as its select.

Parameters:
- N, 8, number of requesters; legal range 2..16.
- IDX_W, 3, width of grant_idx; must satisfy 2^IDX_W >= N.
- MAX_HOLD, 16, maximum cycles a single grant may be held; 0 disables the limit; legal range 0..255.

Ports:
- clk  in  1  single clock; everything updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  N  request vector; req[i] high means requester i wants the resource.
- done  in  1  the current owner pulses this to release the grant; ignored when grant_valid=0.
- grant  out  N  one-hot grant; all zero when idle.
- grant_idx  out  IDX_W  binary index of the granted requester; 0 when idle.
- grant_valid  out  1  high while a grant is active.
- forced_rel  out  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. When rst_n=0 at a rising edge:
  - grant=0, grant_idx=0, grant_valid=0, forced_rel=0;
  - ptr=0, hold_cnt=0, state=IDLE.
- Reset mid-grant:
  - takes effect at that edge regardless of req or done;
  - forced_rel is not pulsed.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Two states, IDLE and BUSY.
- IDLE, req==0: stay in IDLE; outputs stay at their idle values.
- IDLE, req!=0:
  - select the first set bit scanning circularly from ptr upward: ptr, ptr+1, ..., N-1, 0, ..., ptr-1;
  - at the next edge: grant=onehot(sel), grant_idx=sel, grant_valid=1, hold_cnt=1, go to BUSY.
  - Latency: a req sampled at edge k appears as grant after edge k.
- BUSY, release: triggered by any of
  - (a) done=1;
  - (b) req[grant_idx]=0, i.e. the owner withdraws;
  - (c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD.
- On a release at that edge:
  - grant, grant_idx and grant_valid return to idle values;
  - ptr = (grant_idx+1) mod N; when grant_idx=N-1, ptr becomes 0 (this also covers N not a power of 2);
  - go to IDLE.
- forced_rel=1 for exactly the one cycle after the edge, and only when cause (c) is the sole cause; otherwise forced_rel=0.
- BUSY, no release: hold_cnt increments and saturates at 255; grant is unchanged.
- One mandatory idle cycle always follows a release (grant_valid=0), before any new grant.
- Requests from non-owners during BUSY have no effect until the next IDLE arbitration.
- Simultaneous release causes: done together with MAX_HOLD expiry counts as a normal release, so forced_rel=0.
- Fairness: with all N requesters continuously asserting, each is granted exactly once in every N grants, in order ptr, ptr+1, ...
- grant is always exactly one-hot or zero. grant_idx is always the encoding of grant.

Test Plan:
1. Reset then single request: rst_n=0 for 2 cycles, then rst_n=1 with req=8'b0000_0100.
   - Expect: grant=0000_0100, grant_idx=2, grant_valid=1 one cycle after the first sampling edge.
   - After a done pulse: one idle cycle, ptr=3.
2. Full contention rotation: req=8'hFF held, done pulsed every 3rd cycle.
   - Expect grant_idx sequence 0,1,2,3,4,5,6,7,0.
   - Expect an idle cycle between consecutive grants.
3. Wrap-around with N=5: ptr at 4, req=5'b00011.
   - Expect grant_idx=0, then ptr=1; the next arbitration grants 1.
4. MAX_HOLD=4: grant requester 5, keep req[5]=1, done=0.
   - Expect grant revoked after 4 cycles of grant_valid=1, with forced_rel=1 for one cycle.
   - Expect a re-grant of 5 only if no requester in 6..7, 0..4 is asserting.
5. Owner withdraw and coincident causes:
   - Owner drops req mid-grant: release on the next edge, forced_rel=0.
   - done asserted in the same cycle that hold_cnt==MAX_HOLD: forced_rel=0.
6. Reset mid-BUSY: rst_n=0 while grant_idx=6.
   - Expect all outputs zero after that edge and ptr=0.
   - After release of reset with req=8'hFF, expect grant_idx=0.
